// File: rtl/ib_lut_loader_if.sv
// ib_lut_loader_if: LUT image stream in, VN/DN table write ports out.
// master drives the stream, slave is the loader.
interface ib_lut_loader_if #(
  parameter int VN_WR_BW   = 8,
  parameter int DN_WR_BW   = 2,
  parameter int VN_ADDR_BW = 11,
  parameter int DN_ADDR_BW = 11
) ();
  logic                  load_start;
  logic                  load_abort;
  logic                  in_valid;
  logic [VN_WR_BW-1:0]   in_data;
  logic                  in_ready;
  logic [VN_ADDR_BW-1:0] vn_wr_addr;
  logic [VN_WR_BW-1:0]   vn_wr_data;
  logic                  vn_m0_we;
  logic                  vn_m1_we;
  logic [DN_ADDR_BW-1:0] dn_wr_addr;
  logic [DN_WR_BW-1:0]   dn_wr_data;
  logic                  dn_we;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    output load_start, load_abort,
    output in_valid, in_data,
    input  in_ready,
    input  vn_wr_addr, vn_wr_data,
    input  vn_m0_we, vn_m1_we,
    input  dn_wr_addr, dn_wr_data, dn_we,
    input  busy, done, aborted
  );

  modport slave (
    input  load_start, load_abort,
    input  in_valid, in_data,
    output in_ready,
    output vn_wr_addr, vn_wr_data,
    output vn_m0_we, vn_m1_we,
    output dn_wr_addr, dn_wr_data, dn_we,
    output busy, done, aborted
  );
endinterface

// File: rtl/ib_lut_loader.sv
// ib_lut_loader: streams a LUT image into VN m0, VN m1, then DN.
// Writes are registered one cycle after each accepted beat.
module ib_lut_loader #(
  parameter int VN_WR_BW   = 8,
  parameter int DN_WR_BW   = 2,
  parameter int VN_ADDR_BW = 11,
  parameter int DN_ADDR_BW = 11,
  parameter int VN_DEPTH   = 1024,
  parameter int DN_DEPTH   = 1024
) (
  input logic           write_clk,
  input logic           rstn,
  ib_lut_loader_if.slave bus
);
  localparam int CW =
    (VN_ADDR_BW > DN_ADDR_BW) ? VN_ADDR_BW : DN_ADDR_BW;
  localparam logic [CW-1:0] VN_LAST = CW'(VN_DEPTH - 1);
  localparam logic [CW-1:0] DN_LAST = CW'(DN_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, LD_M0, LD_M1, LD_DN, FIN
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          loading;
  logic          abort_now;
  logic          accept;

  assign loading   = (state == LD_M0) ||
                     (state == LD_M1) ||
                     (state == LD_DN);
  assign abort_now = loading & bus.load_abort;
  assign bus.in_ready = loading & ~bus.load_abort;
  assign accept    = bus.in_ready & bus.in_valid;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == FIN);

  // state and word counter
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state: bank advance at DEPTH-1, abort back to IDLE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nx = LD_M0;
          cnt_nx   = '0;
        end
      end
      LD_M0, LD_M1: begin
        if (abort_now) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (accept) begin
          if (cnt == VN_LAST) begin
            state_nx = (state == LD_M0) ? LD_M1 : LD_DN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      LD_DN: begin
        if (abort_now) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (accept) begin
          if (cnt == DN_LAST) begin
            state_nx = FIN;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      FIN: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // registered write ports; addr/data hold between writes
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      bus.vn_wr_addr <= '0;
      bus.vn_wr_data <= '0;
      bus.vn_m0_we   <= 1'b0;
      bus.vn_m1_we   <= 1'b0;
      bus.dn_wr_addr <= '0;
      bus.dn_wr_data <= '0;
      bus.dn_we      <= 1'b0;
      bus.aborted    <= 1'b0;
    end else begin
      bus.vn_m0_we <= accept & (state == LD_M0);
      bus.vn_m1_we <= accept & (state == LD_M1);
      bus.dn_we    <= accept & (state == LD_DN);
      bus.aborted  <= abort_now;
      if (accept && state != LD_DN) begin
        bus.vn_wr_addr <= cnt[VN_ADDR_BW-1:0];
        bus.vn_wr_data <= bus.in_data;
      end
      if (accept && state == LD_DN) begin
        bus.dn_wr_addr <= cnt[DN_ADDR_BW-1:0];
        bus.dn_wr_data <= bus.in_data[DN_WR_BW-1:0];
      end
    end
  end
endmodule
